// File: rtl/mcp3008_responder.sv
// MCP3008/MCP3004 SPI ADC emulator: decodes the start/SGL/D2-D0 command and
// returns a 10-bit value from a host-loaded per-channel table.
module mcp3008_responder #(
   parameter int NUM_CHANNELS = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_clk,
   input  logic        spi_cs_n,
   input  logic        spi_din,
   output logic        spi_dout,
   output logic        spi_dout_oe,
   input  logic        tbl_wr_en,
   input  logic [2:0]  tbl_wr_addr,
   input  logic [9:0]  tbl_wr_data,
   output logic        conv_done,
   output logic [2:0]  conv_channel,
   output logic        conv_sgl,
   output logic [15:0] conv_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_CMD,
      S_SAMPLE,
      S_NULL,
      S_DATA_MSB,
      S_DATA_LSB,
      S_TRAIL
   } state_t;

   localparam logic [3:0] NCH = 4'(NUM_CHANNELS);

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
   logic sclk_q, cs_q, din_q;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] cmd, cmd_n;
   logic [9:0] result;
   logic       dout_n;
   logic       capture;
   logic [2:0] chan;
   logic [9:0] tbl [8];

   // cs_n chain resets high so a released reset never looks like a select.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         din_sync  <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         din_q     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], spi_din};
         sclk_q    <= sclk_sync[SYNC_STAGES-1];
         cs_q      <= cs_sync[SYNC_STAGES-1];
         din_q     <= din_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_q;
   assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_q;
   assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_q;

   assign chan = (NUM_CHANNELS == 4) ? {1'b0, cmd[1:0]} : cmd[2:0];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cmd_n   = cmd;
      dout_n  = spi_dout;
      capture = 1'b0;
      if (cs_rise) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         dout_n  = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               dout_n = 1'b0;
               if (cs_fall) begin
                  state_n = S_WAIT_START;
                  cnt_n   = '0;
               end
            end
            S_WAIT_START: begin
               dout_n = 1'b0;
               if (sclk_rise && din_q) begin
                  state_n = S_CMD;
                  cnt_n   = '0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  cmd_n = {cmd[2:0], din_q};
                  cnt_n = cnt + 4'd1;
                  if (cnt == 4'd3) state_n = S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               if (sclk_rise) begin
                  capture = 1'b1;
                  state_n = S_NULL;
               end
            end
            S_NULL: begin
               if (sclk_fall) begin
                  dout_n  = 1'b0;
                  cnt_n   = '0;
                  state_n = S_DATA_MSB;
               end
            end
            S_DATA_MSB: begin
               if (sclk_fall) begin
                  dout_n = result[4'd9 - cnt];
                  cnt_n  = cnt + 4'd1;
                  // B0 is not repeated: the LSB-first tail starts at B1
                  if (cnt == 4'd9) begin
                     state_n = S_DATA_LSB;
                     cnt_n   = 4'd1;
                  end
               end
            end
            S_DATA_LSB: begin
               if (sclk_fall) begin
                  dout_n = result[cnt];
                  cnt_n  = cnt + 4'd1;
                  if (cnt == 4'd9) state_n = S_TRAIL;
               end
            end
            S_TRAIL: begin
               if (sclk_fall) dout_n = 1'b0;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cmd          <= '0;
         result       <= '0;
         spi_dout     <= 1'b0;
         spi_dout_oe  <= 1'b0;
         conv_done    <= 1'b0;
         conv_channel <= '0;
         conv_sgl     <= 1'b0;
         conv_count   <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         cmd         <= cmd_n;
         spi_dout    <= dout_n;
         spi_dout_oe <= (state_n != S_IDLE);
         conv_done   <= capture;
         if (capture) begin
            result       <= tbl[chan];
            conv_channel <= chan;
            conv_sgl     <= cmd[3];
            conv_count   <= conv_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) tbl[i] <= '0;
      end else if (tbl_wr_en && ({1'b0, tbl_wr_addr} < NCH)) begin
         tbl[tbl_wr_addr] <= tbl_wr_data;
      end
   end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: an SPI master drives an 8-channel and a
// 4-channel responder on a shared bus; results are checked against a table model.
module tb_mcp3008_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_clk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_din = 1'b0;
   logic        tbl_wr_en = 1'b0;
   logic [2:0]  tbl_wr_addr = '0;
   logic [9:0]  tbl_wr_data = '0;

   logic        dout8, oe8, done8, sgl8;
   logic [2:0]  ch8;
   logic [15:0] cnt8;
   logic        dout4, oe4, done4, sgl4;
   logic [2:0]  ch4;
   logic [15:0] cnt4;

   always #5 clk = ~clk;

   mcp3008_responder #(.NUM_CHANNELS(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_din(spi_din),
      .spi_dout(dout8), .spi_dout_oe(oe8),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .conv_done(done8), .conv_channel(ch8), .conv_sgl(sgl8), .conv_count(cnt8));

   mcp3008_responder #(.NUM_CHANNELS(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_din(spi_din),
      .spi_dout(dout4), .spi_dout_oe(oe4),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .conv_done(done4), .conv_channel(ch4), .conv_sgl(sgl4), .conv_count(cnt4));

   int total = 0;
   int bad = 0;

   logic [9:0] m_tbl [8];
   int         m_count = 0;
   int         pulses8 = 0, pulses4 = 0, dbl = 0;
   logic       prev8 = 1'b0;
   logic       rx8 [64];
   logic       rx4 [64];
   int         sample_err;
   int         lat;

   typedef struct {
      int         lead;
      logic       sgl;
      logic [2:0] ch;
      int         nrise;
      logic [9:0] val;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs [6];

   always @(negedge clk) begin
      if (done8 === 1'b1) pulses8++;
      if (done4 === 1'b1) pulses4++;
      if (done8 === 1'b1 && prev8 === 1'b1) dbl++;
      prev8 = done8;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bit the master should see at rise k (k=1 is the start bit) for value v.
   function automatic logic exp_bit(input int k, input logic [9:0] v);
      if (k >= 8 && k <= 17) return v[17 - k];
      if (k >= 18 && k <= 26) return v[k - 17];
      return 1'b0;
   endfunction

   task automatic tb_write(input logic [2:0] a, input logic [9:0] d);
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = a;
      tbl_wr_data = d;
      @(negedge clk);
      tbl_wr_en = 1'b0;
      m_tbl[a]  = d;
   endtask

   task automatic spi_txn(input int lead, input logic sgl, input logic [2:0] ch, input int nrise,
                          input logic wr_hook, input logic [9:0] wr_val);
      int   k;
      logic b;
      sample_err = 0;
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < lead + nrise; i++) begin
         k = i - lead + 1;
         b = (k == 1) ? 1'b1 : (k == 2) ? sgl : (k == 3) ? ch[2] :
             (k == 4) ? ch[1] : (k == 5) ? ch[0] : 1'b0;
         spi_din = b;
         repeat (4) @(negedge clk);
         if (oe8 !== 1'b1 || oe4 !== 1'b1) sample_err++;
         if (k >= 1) begin
            rx8[k] = dout8;
            rx4[k] = dout4;
         end else if (dout8 !== 1'b0 || dout4 !== 1'b0) begin
            sample_err++;
         end
         spi_clk = 1'b1;
         for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (wr_hook && k == 6 && j == 2) begin
               tbl_wr_en   = 1'b1;
               tbl_wr_addr = ch;
               tbl_wr_data = wr_val;
            end
            if (wr_hook && k == 6 && j == 3) begin
               tbl_wr_en = 1'b0;
               check("wr_same_cycle_conv_done", {31'd0, done8}, 32'd1);
            end
         end
         spi_clk = 1'b0;
      end
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b1;
      lat = 0;
      while (oe8 === 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic do_txn(input string tag, input int lead, input logic sgl, input logic [2:0] ch,
                         input int nrise, input logic wr_hook, input logic [9:0] wr_val,
                         input logic [9:0] v8);
      logic [9:0]  v4;
      logic [31:0] got8, got4, exp8, exp4;
      logic [9:0]  res8;
      int          p8, p4, exp_p;
      v4 = m_tbl[{1'b0, ch[1:0]}];
      p8 = pulses8;
      p4 = pulses4;
      spi_txn(lead, sgl, ch, nrise, wr_hook, wr_val);
      if (wr_hook) m_tbl[ch] = wr_val;
      got8 = '0; got4 = '0; exp8 = '0; exp4 = '0;
      for (int k = 1; k <= nrise && k <= 32; k++) begin
         got8[k-1] = rx8[k];
         got4[k-1] = rx4[k];
         exp8[k-1] = exp_bit(k, v8);
         exp4[k-1] = exp_bit(k, v4);
      end
      check({tag, " stream8"}, got8, exp8);
      check({tag, " stream4"}, got4, exp4);
      if (nrise >= 17) begin
         for (int k = 8; k <= 17; k++) res8[17 - k] = rx8[k];
         check({tag, " result8"}, {22'd0, res8}, {22'd0, v8});
      end
      check({tag, " oe_and_leading_zeros"}, sample_err, 0);
      exp_p = (nrise >= 6) ? 1 : 0;
      m_count += exp_p;
      check({tag, " conv_pulses8"}, pulses8 - p8, exp_p);
      check({tag, " conv_pulses4"}, pulses4 - p4, exp_p);
      if (nrise >= 6) begin
         check({tag, " conv_channel8"}, {29'd0, ch8}, {29'd0, ch});
         check({tag, " conv_sgl8"}, {31'd0, sgl8}, {31'd0, sgl});
         check({tag, " conv_channel4"}, {29'd0, ch4}, {30'd0, ch[1:0]});
      end
      check({tag, " conv_count8"}, {16'd0, cnt8}, m_count & 32'hFFFF);
      check({tag, " conv_count4"}, {16'd0, cnt4}, m_count & 32'hFFFF);
      check({tag, " oe_off_latency_ok"}, {31'd0, (lat <= 4)}, 32'd1);
   endtask

   initial begin
      logic [2:0] rch;
      int         rlead, rn;
      logic       rsgl;
      int         p8;

      for (int i = 0; i < 8; i++) m_tbl[i] = '0;
      vecs[0] = '{0, 1'b1, 3'd3, 30, 10'h2A5, 10'h2A5};
      vecs[1] = '{3, 1'b1, 3'd5, 30, 10'h3FF, 10'h3FF};
      vecs[2] = '{0, 1'b0, 3'd2, 30, 10'h155, 10'h155};
      vecs[3] = '{1, 1'b1, 3'd0, 30, 10'h001, 10'h001};
      vecs[4] = '{0, 1'b1, 3'd7, 28, 10'h000, 10'h000};
      vecs[5] = '{2, 1'b0, 3'd4, 30, 10'h3C3, 10'h3C3};

      repeat (5) @(negedge clk);
      check("oe_in_reset", {31'd0, oe8}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_oe", {30'd0, oe8, oe4}, 32'd0);
      check("idle_dout", {30'd0, dout8, dout4}, 32'd0);
      check("idle_count", {16'd0, cnt8}, 32'd0);
      check("idle_no_pulse", pulses8 + pulses4, 0);

      for (int i = 0; i < 6; i++) begin
         tb_write(vecs[i].ch, vecs[i].val);
         do_txn($sformatf("vec%0d", i), vecs[i].lead, vecs[i].sgl, vecs[i].ch,
                vecs[i].nrise, 1'b0, 10'h000, vecs[i].exp);
      end

      // Abort after rise 10, then a fresh transaction on channel 0.
      tb_write(3'd0, 10'h001);
      do_txn("abort", 0, 1'b1, 3'd3, 10, 1'b0, 10'h000, m_tbl[3]);
      do_txn("after_abort", 0, 1'b1, 3'd0, 30, 1'b0, 10'h000, 10'h001);

      // Back-to-back scan with a same-cycle write to channel 1.
      tb_write(3'd0, 10'h100);
      tb_write(3'd1, 10'h0FF);
      tb_write(3'd2, 10'h3C3);
      do_txn("scan0", 0, 1'b1, 3'd0, 18, 1'b0, 10'h000, 10'h100);
      do_txn("scan1", 0, 1'b1, 3'd1, 18, 1'b1, 10'h000, 10'h0FF);
      do_txn("scan2", 0, 1'b1, 3'd2, 18, 1'b0, 10'h000, 10'h3C3);
      do_txn("scan1_again", 0, 1'b1, 3'd1, 18, 1'b0, 10'h000, 10'h000);

      // D2=1, D1D0=2: 8-channel returns table[6], 4-channel returns table[2].
      tb_write(3'd2, 10'h2B4);
      tb_write(3'd6, 10'h11E);
      do_txn("d2_ignored", 1, 1'b0, 3'd6, 30, 1'b0, 10'h000, 10'h11E);

      for (int i = 0; i < 16; i++) begin
         rch   = 3'($urandom_range(0, 7));
         rsgl  = 1'($urandom_range(0, 1));
         rlead = $urandom_range(0, 3);
         rn    = $urandom_range(6, 30);
         if ($urandom_range(0, 1) == 1) tb_write(rch, 10'($urandom));
         do_txn($sformatf("rand%0d", i), rlead, rsgl, rch, rn, 1'b0, 10'h000, m_tbl[rch]);
      end

      // Reset in the middle of a command.
      p8 = pulses8;
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         spi_din = 1'b1;
         repeat (4) @(negedge clk);
         spi_clk = 1'b1;
         repeat (4) @(negedge clk);
         spi_clk = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset_oe", {30'd0, oe8, oe4}, 32'd0);
      check("mid_reset_count", {16'd0, cnt8}, 32'd0);
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_din  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_reset_no_pulse", pulses8 - p8, 0);
      check("mid_reset_idle_oe", {31'd0, oe8}, 32'd0);
      m_count = 0;
      for (int i = 0; i < 8; i++) m_tbl[i] = '0;
      do_txn("post_reset_tbl_clear", 0, 1'b1, 3'd3, 30, 1'b0, 10'h000, 10'h000);

      check("single_cycle_pulses", dbl, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
